// File: rtl/beam_sample_streamer.sv
// Sample RAM to beamformer streamer: reads a block, holds each index/value pair HOLD_CYCLES cycles,
// prefetching the next sample READ_LATENCY edges after each present edge.
module beam_sample_streamer #(
    parameter int ADDR_W       = 10,
    parameter int READ_LATENCY = 2,
    parameter int HOLD_CYCLES  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [15:0]       sample_count,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [31:0]       ram_q,
    output logic [31:0]       stream_value,
    output logic [15:0]       stream_index,
    output logic              stream_active,
    output logic              busy,
    output logic              done
);

    // state  | meaning
    // IDLE   | waiting for start
    // PRIME  | first RAM read in flight, counting READ_LATENCY edges
    // STREAM | presenting pairs, prefetching the next one
    // FINISH | done pulse, then back to IDLE

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] CAPTURE_CNT = HOLD_W'(READ_LATENCY - 1);
    localparam logic [HOLD_W-1:0] LAST_HOLD   = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [ADDR_W:0]   MAX_N       = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {IDLE, PRIME, STREAM, FINISH} state_t;

    state_t            state, next_state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [ADDR_W-1:0] last_idx;
    logic [31:0]       prefetch;
    logic [ADDR_W:0]   count_clamped;
    logic              is_last;

    always_comb begin
        count_clamped = (int'(sample_count) > int'(MAX_N)) ? MAX_N : sample_count[ADDR_W:0];
        is_last       = (stream_index[ADDR_W-1:0] == last_idx);
        busy          = (state != IDLE);
        done          = (state == FINISH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (start) next_state = (count_clamped == '0) ? FINISH : PRIME;
            PRIME:  if (hold_cnt == CAPTURE_CNT) next_state = STREAM;
            STREAM: if (hold_cnt == LAST_HOLD && is_last) next_state = FINISH;
            FINISH: next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (abort && state != IDLE) next_state = IDLE;
    end

    // last_idx wraps to all-ones for a full 2^ADDR_W block, which is exactly N-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt      <= '0;
            last_idx      <= '0;
            prefetch      <= '0;
            ram_addr      <= '0;
            stream_value  <= '0;
            stream_index  <= '0;
            stream_active <= 1'b0;
        end else if (abort && state != IDLE) begin
            stream_active <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        last_idx <= count_clamped[ADDR_W-1:0] - 1'b1;
                        hold_cnt <= '0;
                        if (count_clamped != '0) ram_addr <= '0;
                    end
                end
                PRIME: begin
                    if (hold_cnt == CAPTURE_CNT) begin
                        stream_value  <= ram_q;
                        stream_index  <= '0;
                        stream_active <= 1'b1;
                        hold_cnt      <= '0;
                        if (ram_addr != last_idx) ram_addr <= ram_addr + 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                STREAM: begin
                    if (hold_cnt == CAPTURE_CNT) prefetch <= ram_q;
                    if (hold_cnt == LAST_HOLD) begin
                        hold_cnt <= '0;
                        if (is_last) begin
                            stream_active <= 1'b0;
                        end else begin
                            stream_value <= prefetch;
                            stream_index <= stream_index + 16'd1;
                            if (ram_addr != last_idx) ram_addr <= ram_addr + 1'b1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_beam_sample_streamer.sv
// Randomized bench for beam_sample_streamer: two instances (HOLD 4 and HOLD 3) checked every cycle
// against an arithmetic timeline model of the stream.
module tb_beam_sample_streamer;

    localparam int RL = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start0 = 1'b0, start1 = 1'b0, abort0 = 1'b0, abort1 = 1'b0;
    logic [15:0] sample_count = '0;
    logic [9:0]  addr0, addr1;
    logic [31:0] q0 = '0, q1 = '0, val0, val1;
    logic [15:0] idx0, idx1;
    logic        act0, act1, busy0, busy1, done0, done1;
    logic [31:0] mem [1024];

    int          checks = 0;
    int          errors = 0;
    int          prev_idx [2];
    int          prev_addr [2];
    logic [31:0] prev_val [2];

    always #5 clk = ~clk;

    // one registered stage: address set at edge E is captured by the DUT at edge E+2
    always @(posedge clk) begin
        q0 <= mem[addr0];
        q1 <= mem[addr1];
    end

    beam_sample_streamer #(.ADDR_W(10), .READ_LATENCY(RL), .HOLD_CYCLES(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .sample_count(sample_count),
        .ram_addr(addr0), .ram_q(q0), .stream_value(val0), .stream_index(idx0),
        .stream_active(act0), .busy(busy0), .done(done0));

    beam_sample_streamer #(.ADDR_W(10), .READ_LATENCY(RL), .HOLD_CYCLES(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .sample_count(sample_count),
        .ram_addr(addr1), .ram_q(q1), .stream_value(val1), .stream_index(idx1),
        .stream_active(act1), .busy(busy1), .done(done1));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_zero(input int which);
        check("rst_value",  which ? val1 : val0, 32'h0);
        check("rst_index",  32'(which ? idx1 : idx0), 32'h0);
        check("rst_addr",   32'(which ? addr1 : addr0), 32'h0);
        check("rst_active", 32'(which ? act1 : act0), 32'h0);
        check("rst_busy",   32'(which ? busy1 : busy0), 32'h0);
        check("rst_done",   32'(which ? done1 : done0), 32'h0);
    endtask

    // d counts edges after the accepted start edge E0; d_a is the edge that samples abort (0 = none)
    task automatic run_block(input int which, input int n, input int d_a, input bit seq_fill);
        int          h, nn, end_d, d_eff, k, e_idx, e_addr;
        logic [31:0] e_val;
        bit          e_act, e_busy, e_done, aborted;
        h  = which ? 3 : 4;
        nn = (n > 1024) ? 1024 : n;
        for (int i = 0; i < 1024; i++) mem[i] = seq_fill ? 32'hA000_0000 + 32'(i) : $urandom;
        @(negedge clk);
        sample_count = 16'(n);
        if (which != 0) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clk);
        end_d = (nn == 0) ? 1 : ((d_a > 0) ? d_a : RL + nn * h + 1);
        e_idx = prev_idx[which]; e_val = prev_val[which]; e_addr = prev_addr[which];
        for (int d = 0; d <= end_d + 1; d++) begin
            @(negedge clk);
            aborted = (d_a > 0) && (d >= d_a);
            d_eff   = aborted ? d_a - 1 : d;
            if (nn == 0) begin
                e_act = 1'b0; e_busy = (d == 0); e_done = (d == 0);
                e_idx = prev_idx[which]; e_val = prev_val[which]; e_addr = prev_addr[which];
            end else begin
                e_act  = !aborted && d >= RL && d < RL + nn * h;
                e_busy = !aborted && d <= RL + nn * h;
                e_done = !aborted && d == RL + nn * h;
                if (d_eff < RL) begin
                    e_idx = prev_idx[which]; e_val = prev_val[which]; e_addr = 0;
                end else begin
                    k = (d_eff - RL) / h;
                    if (k > nn - 1) k = nn - 1;
                    e_idx  = k;
                    e_val  = mem[k];
                    e_addr = (k + 1 > nn - 1) ? nn - 1 : k + 1;
                end
            end
            check("value",  which ? val1 : val0, e_val);
            check("index",  32'(which ? idx1 : idx0), 32'(e_idx));
            check("addr",   32'(which ? addr1 : addr0), 32'(e_addr));
            check("active", 32'(which ? act1 : act0), 32'(e_act));
            check("busy",   32'(which ? busy1 : busy0), 32'(e_busy));
            check("done",   32'(which ? done1 : done0), 32'(e_done));
            // stray starts and count changes while busy must not disturb the block
            sample_count = 16'($urandom);
            if (which != 0) begin
                start1 = e_busy ? 1'($urandom_range(0, 1)) : 1'b0;
                abort1 = (d + 1 == d_a);
            end else begin
                start0 = e_busy ? 1'($urandom_range(0, 1)) : 1'b0;
                abort0 = (d + 1 == d_a);
            end
        end
        start0 = 1'b0; start1 = 1'b0; abort0 = 1'b0; abort1 = 1'b0;
        prev_idx[which] = e_idx; prev_val[which] = e_val; prev_addr[which] = e_addr;
    endtask

    initial begin
        int n, d_a;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        for (int w = 0; w < 2; w++) begin
            prev_idx[w] = 0; prev_addr[w] = 0; prev_val[w] = '0;
        end
        #2 rst_n = 1'b0;
        #1;
        check_zero(0);
        check_zero(1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_block(0, 4, 0, 1'b1);
        run_block(0, 1, 0, 1'b0);
        run_block(0, 0, 0, 1'b0);
        run_block(0, 8, RL + 2 * 4 + 1, 1'b0);

        // reset in the middle of a block, no clock edge before the check
        @(negedge clk);
        sample_count = 16'd5;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_zero(0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int w = 0; w < 2; w++) begin
            prev_idx[w] = 0; prev_addr[w] = 0; prev_val[w] = '0;
        end
        run_block(0, 3, 0, 1'b0);

        repeat (8) begin
            n   = $urandom_range(0, 12);
            d_a = (n > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, RL + n * 4) : 0;
            run_block(0, n, d_a, 1'b0);
        end
        repeat (3) begin
            n = $urandom_range(1, 9);
            run_block(1, n, 0, 1'b0);
        end

        run_block(1, 2000, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
